// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - multi-channel programmable pulse-train generator
module pulse_train_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int RPT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start_in,
  input  logic [NUM_CH-1:0]       stop_in,
  input  logic [NUM_CH*CNT_W-1:0] delay_in,
  input  logic [NUM_CH*CNT_W-1:0] high_in,
  input  logic [NUM_CH*CNT_W-1:0] low_in,
  input  logic [NUM_CH*RPT_W-1:0] repeat_in,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy_out,
  output logic [NUM_CH-1:0]       done_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RPT_W-1:0] RPT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] dly_q;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] lo_q;
    logic [RPT_W-1:0] rpt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RPT_W-1:0] pcnt_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] dly_c;
    logic [CNT_W-1:0] hi_c;
    logic [CNT_W-1:0] lo_c;
    logic [RPT_W-1:0] rpt_c;
    logic [CNT_W-1:0] lo_last;
    logic [RPT_W-1:0] pcnt_d;
    logic             train_end;

    assign dly_c = delay_in[c*CNT_W +: CNT_W];
    assign hi_c  = high_in[c*CNT_W +: CNT_W];
    assign lo_c  = low_in[c*CNT_W +: CNT_W];
    assign rpt_c = repeat_in[c*RPT_W +: RPT_W];

    // A zero low width still gets one low cycle so adjacent pulses never merge.
    assign lo_last   = (lo_q == '0) ? '0 : (lo_q - CNT_ONE);
    // Pulse counter after the current high phase; wraps freely in continuous mode.
    assign pcnt_d    = pcnt_q + RPT_ONE;
    assign train_end = (rpt_q != '0) && (pcnt_d == rpt_q);

    // Channel FSM: phase sequencing, cycle/pulse counting and registered outputs.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        dly_q   <= '0;
        hi_q    <= '0;
        lo_q    <= '0;
        rpt_q   <= '0;
        cnt_q   <= '0;
        pcnt_q  <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (start_in[c] && !stop_in[c]) begin
              dly_q  <= dly_c;
              hi_q   <= hi_c;
              lo_q   <= lo_c;
              rpt_q  <= rpt_c;
              cnt_q  <= '0;
              pcnt_q <= '0;
              if (hi_c == '0) begin
                // Degenerate train: report completion without ever going busy.
                done_q <= 1'b1;
              end else if (dly_c != '0) begin
                state_q <= ST_DELAY;
                busy_q  <= 1'b1;
              end else begin
                state_q <= ST_HIGH;
                busy_q  <= 1'b1;
                pulse_q <= 1'b1;
              end
            end
          end

          ST_DELAY: begin
            if (stop_in[c]) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              pulse_q <= 1'b0;
            end else if (cnt_q == dly_q - CNT_ONE) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          ST_HIGH: begin
            if (stop_in[c]) begin
              // Abort takes priority over a train finishing this cycle.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              pulse_q <= 1'b0;
            end else if (cnt_q == hi_q - CNT_ONE) begin
              pcnt_q  <= pcnt_d;
              cnt_q   <= '0;
              pulse_q <= 1'b0;
              if (train_end) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_LOW;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          ST_LOW: begin
            if (stop_in[c]) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              pulse_q <= 1'b0;
            end else if (cnt_q == lo_last) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
          end
        endcase
      end
    end

    assign pulse_out[c] = pulse_q;
    assign busy_out[c]  = busy_q;
    assign done_out[c]  = done_q;
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen against an arithmetic train model
module tb_pulse_train_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int RPT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       start_in;
  logic [NUM_CH-1:0]       stop_in;
  logic [NUM_CH*CNT_W-1:0] delay_in;
  logic [NUM_CH*CNT_W-1:0] high_in;
  logic [NUM_CH*CNT_W-1:0] low_in;
  logic [NUM_CH*RPT_W-1:0] repeat_in;
  logic [NUM_CH-1:0]       pulse_out;
  logic [NUM_CH-1:0]       busy_out;
  logic [NUM_CH-1:0]       done_out;

  always #5 clk = ~clk;

  pulse_train_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in),
    .delay_in(delay_in), .high_in(high_in), .low_in(low_in), .repeat_in(repeat_in),
    .pulse_out(pulse_out), .busy_out(busy_out), .done_out(done_out)
  );

  int unsigned cfg_d [NUM_CH];
  int unsigned cfg_h [NUM_CH];
  int unsigned cfg_l [NUM_CH];
  int unsigned cfg_n [NUM_CH];

  // Pack the per-channel configuration arrays onto the DUT buses.
  always_comb begin
    delay_in  = '0;
    high_in   = '0;
    low_in    = '0;
    repeat_in = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      delay_in[ch*CNT_W +: CNT_W]  = cfg_d[ch][CNT_W-1:0];
      high_in[ch*CNT_W +: CNT_W]   = cfg_h[ch][CNT_W-1:0];
      low_in[ch*CNT_W +: CNT_W]    = cfg_l[ch][CNT_W-1:0];
      repeat_in[ch*RPT_W +: RPT_W] = cfg_n[ch][RPT_W-1:0];
    end
  end

  typedef struct packed {
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] d;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a running train is described by its start cycle and config,
  // and the output at any later cycle is derived from the offset arithmetically.
  bit      m_act [NUM_CH];
  longint  m_t0  [NUM_CH];
  longint  m_d   [NUM_CH];
  longint  m_h   [NUM_CH];
  longint  m_l   [NUM_CH];
  longint  m_n   [NUM_CH];
  longint  cyc = 0;

  int checks = 0;
  int passed = 0;

  task automatic eval_train(input int ch, input longint t, output logic p, output logic b, output logic dn);
    longint o, per, q, endp;
    p = 1'b0; b = 1'b0; dn = 1'b0;
    o = t - m_t0[ch];
    per = m_h[ch] + ((m_l[ch] == 0) ? 1 : m_l[ch]);
    if (o < m_d[ch]) begin
      b = 1'b1;
    end else begin
      q = o - m_d[ch];
      endp = (m_n[ch] - 1) * per + m_h[ch];
      if (m_n[ch] != 0 && q == endp) begin
        dn = 1'b1;
        m_act[ch] = 1'b0;
      end else begin
        b = 1'b1;
        p = ((q % per) < m_h[ch]);
      end
    end
  endtask

  // Predict outputs for the next cycle from the inputs now applied, queue them, advance.
  task automatic tick();
    exp_t e;
    logic p, b, dn;
    e = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      p = 1'b0; b = 1'b0; dn = 1'b0;
      if (!rst_n) begin
        m_act[ch] = 1'b0;
      end else if (m_act[ch]) begin
        if (stop_in[ch]) m_act[ch] = 1'b0;
        else eval_train(ch, cyc + 1, p, b, dn);
      end else if (start_in[ch] && !stop_in[ch]) begin
        m_d[ch] = cfg_d[ch]; m_h[ch] = cfg_h[ch];
        m_l[ch] = cfg_l[ch]; m_n[ch] = cfg_n[ch];
        if (m_h[ch] == 0) begin
          dn = 1'b1;
        end else begin
          m_act[ch] = 1'b1;
          m_t0[ch]  = cyc + 1;
          eval_train(ch, cyc + 1, p, b, dn);
        end
      end
      e.p[ch] = p; e.b[ch] = b; e.d[ch] = dn;
    end
    exp_q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int ch, input int unsigned d, input int unsigned h,
                         input int unsigned l, input int unsigned n);
    cfg_d[ch] = d; cfg_h[ch] = h; cfg_l[ch] = l; cfg_n[ch] = n;
  endtask

  task automatic pulse_start(input int ch);
    start_in[ch] = 1'b1;
    tick();
    start_in[ch] = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents outputs, pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int ch = 0; ch < NUM_CH; ch++) begin
          checks++;
          if ({pulse_out[ch], busy_out[ch], done_out[ch]} !== {e.p[ch], e.b[ch], e.d[ch]}) begin
            $display("FAIL ch%0d_pbd t=%0t got pulse/busy/done=%b%b%b want %b%b%b",
                     ch, $time, pulse_out[ch], busy_out[ch], done_out[ch],
                     e.p[ch], e.b[ch], e.d[ch]);
          end else begin
            passed++;
          end
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    rst_n    = 1'b0;
    start_in = '0;
    stop_in  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      set_cfg(ch, 0, 0, 0, 0);
      m_act[ch] = 1'b0;
    end
    ticks(3);
    rst_n = 1'b1;
    ticks(2);

    // D=0 H=3 L=2 N=2 two-pulse train.
    set_cfg(0, 0, 3, 2, 2);
    pulse_start(0);
    ticks(12);

    // Start delay of four then a single one-cycle pulse.
    set_cfg(0, 4, 1, 0, 1);
    pulse_start(0);
    ticks(8);

    // Continuous H=2 L=0, stopped after 20 cycles; counter wraps past 2^RPT_W pulses.
    set_cfg(0, 0, 2, 0, 0);
    pulse_start(0);
    ticks(19);
    stop_in[0] = 1'b1;
    tick();
    stop_in[0] = 1'b0;
    ticks(3);
    set_cfg(1, 0, 1, 0, 0);
    pulse_start(1);
    ticks(45);
    stop_in[1] = 1'b1;
    tick();
    stop_in[1] = 1'b0;
    ticks(2);

    // Start held high while busy with new H: ignored, then re-accepted right after done.
    set_cfg(2, 1, 2, 1, 3);
    start_in[2] = 1'b1;
    tick();
    set_cfg(2, 0, 5, 0, 1);
    ticks(14);
    start_in[2] = 1'b0;
    ticks(8);

    // Degenerate H=0 train, then start+stop together in IDLE.
    set_cfg(3, 2, 0, 1, 1);
    pulse_start(3);
    ticks(3);
    set_cfg(3, 0, 2, 1, 1);
    start_in[3] = 1'b1; stop_in[3] = 1'b1;
    tick();
    start_in[3] = 1'b0; stop_in[3] = 1'b0;
    ticks(4);

    // Maximum counts and maximum repeat count.
    set_cfg(0, 255, 255, 255, 2);
    set_cfg(1, 0, 1, 0, 15);
    start_in[0] = 1'b1; start_in[1] = 1'b1;
    tick();
    start_in = '0;
    ticks(1030);

    // Stop landing on the final high cycle suppresses done.
    set_cfg(0, 0, 2, 1, 1);
    pulse_start(0);
    tick();
    stop_in[0] = 1'b1;
    tick();
    stop_in[0] = 1'b0;
    ticks(3);

    // Four channels at once, then a second run cut short by reset.
    set_cfg(0, 0, 3, 2, 2);
    set_cfg(1, 2, 1, 0, 3);
    set_cfg(2, 1, 2, 3, 0);
    set_cfg(3, 3, 4, 1, 1);
    start_in = '1;
    tick();
    start_in = '0;
    ticks(25);
    start_in = '1;
    tick();
    start_in = '0;
    ticks(4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(4);

    // Randomised traffic: config churn, level/strobe starts, occasional stop and reset.
    for (int i = 0; i < 2500; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 3) == 0)
          set_cfg(ch, $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        start_in[ch] = ($urandom_range(0, 9) < 3);
        stop_in[ch]  = ($urandom_range(0, 49) == 0);
      end
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    start_in = '0;
    stop_in  = '0;
    rst_n    = 1'b1;
    tick();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Multi-channel, parametrised pulse-train generator for timing and strobe generation in the video/HDMI datapath, e.g. sync-width strobes, test-pattern triggers and DMA kick pulses. Each channel works independently. On a start request it latches a start delay, a high width, a low width and a repeat count, then emits the programmed train on its output. Beyond single-pulse generation it adds start delay, trains of repeated pulses, continuous mode, abort, and a busy flag per channel.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 32, width of the delay, high and low cycle counts
RPT_W, 16, width of the repeat count

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start_in  in  NUM_CH  per-channel start request, 1-cycle strobe or level (sampled every cycle)
stop_in  in  NUM_CH  per-channel abort request
delay_in  in  NUM_CH*CNT_W  cycles from start to the first rising edge; channel c uses bits [c*CNT_W +: CNT_W]
high_in  in  NUM_CH*CNT_W  high-phase length in cycles
low_in  in  NUM_CH*CNT_W  low-phase length between pulses in cycles
repeat_in  in  NUM_CH*RPT_W  number of pulses; 0 = continuous
pulse_out  out  NUM_CH  registered pulse output
busy_out  out  NUM_CH  channel is executing a train
done_out  out  NUM_CH  1-cycle strobe on normal train completion

Behaviour:
- Reset (rst_n=0 at a clk edge): every channel goes to IDLE. pulse_out=0, busy_out=0, done_out=0, all counters and latched config cleared. Reset mid-train aborts the train with no done.
- Per-channel FSM: IDLE, DELAY, HIGH, LOW. All outputs are registered.
- IDLE:
  - If start_in[c]=1 and stop_in[c]=0 in cycle k, latch D/H/L/N from the channel's slices.
  - H=0 gives a degenerate train: no pulse, busy stays 0, done_out=1 in cycle k+1, channel stays IDLE.
  - Otherwise go to DELAY if D>0, else HIGH. busy_out=1 from cycle k+1.
- DELAY: lasts exactly D cycles (k+1..k+D), pulse_out=0. Then go to HIGH.
- HIGH: pulse_out=1 for exactly H cycles. First high cycle = k+1+D.
  - At the end of a high phase, increment the pulse counter.
  - If N≠0 and the counter equals N, the train is done: return to IDLE. In the next cycle pulse_out=0, busy_out=0 and done_out=1 together.
  - Otherwise go to LOW.
- LOW: pulse_out=0 for max(L,1) cycles. L=0 is treated as 1 so pulses never merge. Then go to HIGH.
- N=0 (continuous): the train repeats until stop_in or reset. The pulse counter wraps silently.
- stop_in[c]=1 in any non-IDLE state in cycle j:
  - In cycle j+1: pulse_out=0, busy_out=0, done_out=0, state IDLE.
  - stop wins over a train completing in the same cycle; no done is produced.
- start_in while busy is ignored and leaves the latched config unchanged; no restart.
- start_in in the cycle after done/abort (state IDLE) is accepted normally. Back-to-back trains are gap-free apart from the one IDLE cycle.
- start_in and stop_in together in IDLE: stop wins and start is ignored.
- Config inputs are sampled only at the accepting start. Changes during a train have no effect.
- Counters are CNT_W bits wide and compare against the latched value minus 1. Maximum values (2^CNT_W−1) must work with no overflow or premature termination.
- Channels share no state. Simultaneous starts, stops and completions on different channels are fully independent.

Test Plan:
- D=0, H=3, L=2, N=2, start in cycle 10 -> pulse_out=1 in cycles 11-13 and 16-18, 0 in 14-15; busy_out=1 in 11-18; done_out=1 only in cycle 19, with busy_out=0 in cycle 19.
- D=4, H=1, N=1, start in cycle 5 -> pulse_out=0 in 6-9 and =1 only in cycle 10; done_out=1 in cycle 11.
- N=0, H=2, L=0, start in cycle 0, stop in cycle 20 -> pattern 1,1,0 repeating from cycle 1; pulse_out=0 and busy_out=0 from cycle 21; done_out never asserts.
- Start re-asserted while busy with different H -> train continues with the original H. Start in the cycle after done -> new train accepted, busy_out=1 in the next cycle.
- H=0, start in cycle 3 -> done_out=1 in cycle 4, pulse_out and busy_out never 1. Start+stop in the same IDLE cycle -> nothing happens.
- Four channels started in the same cycle with distinct configs, and rst_n=0 asserted mid-train on a second run -> each channel matches its reference model independently; all outputs 0 the cycle after reset with no done strobe.
